uart_alu_ctrl: RTL

Sequencer between the UART receiver, the ALU and the UART transmitter. It collects three received bytes (operand A, operand B, opcode) from the RX byte-done strobe and drives them to the combinational ALU. It then captures the ALU result and launches a single TX transfer, waiting for TX completion before accepting the next frame. An inter-byte timeout discards partial frames, and a sticky overrun flag records bytes dropped while busy.

---
 rtl/uart_alu_if.sv | 25 ++
 rtl/uart_alu_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if: byte/ALU/TX handshake bundle between the frame sequencer and its UART/ALU peers.
interface uart_alu_if #(
  parameter int NBITS = 8,
  parameter int NOP   = 6
);
  logic             rx_done;
  logic [NBITS-1:0] rx_data;
  logic [NBITS-1:0] alu_result;
  logic             tx_done;
  logic [NBITS-1:0] alu_a;
  logic [NBITS-1:0] alu_b;
  logic [NOP-1:0]   alu_op;
  logic             tx_start;
  logic [NBITS-1:0] tx_data;
  logic             timeout;
  logic             overrun;
  modport master (
    input  rx_done, rx_data, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_start, tx_data, timeout, overrun
  );
  modport slave (
    output rx_done, rx_data, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, timeout, overrun
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: gathers A/B/opcode bytes from UART RX, feeds the ALU, sends one result byte per frame.
module uart_alu_ctrl #(
  parameter int NBITS   = 8,
  parameter int NOP     = 6,
  parameter int TIMEOUT = 1000000
) (
  input logic clk,
  input logic rst,
  uart_alu_if.master bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NBITS-1:0] a_n, b_n, tx_data_n;
  logic [NOP-1:0] op_n;
  logic tx_start_n, timeout_n, overrun_n, waiting, busy, expire;
  assign waiting = state == WAIT_B || state == WAIT_OP;
  assign busy = state == SEND || state == WAIT_TX;
  // A byte arriving on the terminal-count cycle beats the timeout.
  assign expire = TIMEOUT > 0 && waiting && !bus.rx_done && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    a_n = bus.alu_a;
    b_n = bus.alu_b;
    op_n = bus.alu_op;
    tx_data_n = bus.tx_data;
    tx_start_n = 1'b0;
    timeout_n = 1'b0;
    overrun_n = bus.overrun | (bus.rx_done & busy);
    cnt_n = (TIMEOUT > 0 && waiting && !bus.rx_done && !expire) ? cnt + CW'(1) : '0;
    case (state)
      WAIT_A: begin
        a_n = bus.rx_done ? bus.rx_data : bus.alu_a;
        state_n = bus.rx_done ? WAIT_B : WAIT_A;
      end
      WAIT_B: begin
        b_n = bus.rx_done ? bus.rx_data : bus.alu_b;
        state_n = bus.rx_done ? WAIT_OP : expire ? WAIT_A : WAIT_B;
        timeout_n = expire;
      end
      WAIT_OP: begin
        op_n = bus.rx_done ? bus.rx_data[NOP-1:0] : bus.alu_op;
        state_n = bus.rx_done ? SEND : expire ? WAIT_A : WAIT_OP;
        timeout_n = expire;
      end
      SEND: begin
        tx_data_n = bus.alu_result;
        tx_start_n = 1'b1;
        state_n = WAIT_TX;
      end
      WAIT_TX: state_n = bus.tx_done ? WAIT_A : WAIT_TX;
      default: state_n = WAIT_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_A;
      cnt <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.tx_data <= '0;
      bus.tx_start <= 1'b0;
      bus.timeout <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.alu_a <= a_n;
      bus.alu_b <= b_n;
      bus.alu_op <= op_n;
      bus.tx_data <= tx_data_n;
      bus.tx_start <= tx_start_n;
      bus.timeout <= timeout_n;
      bus.overrun <= overrun_n;
    end
  end
endmodule
